// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sweeps a 16:1 bit-mux select and gathers the sampled bits into a word.
// Optional macro MUX_SCAN_PARITY_EN adds a parity output that tracks word.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   start  - scan request, sampled only while idle
//   y_in   - mux output bit for the currently driven select
//   s      - registered mux select
//   busy   - high whenever a scan is in flight (including the done cycle)
//   done   - one-cycle pulse when a completed word is presented
//   word   - captured word, bit k = y_in sampled while s == k
//   valid  - sticky, set once any scan has completed since reset
//   parity - (MUX_SCAN_PARITY_EN only) XOR of all bits of word
module mux_scan_ctrl #(
    parameter int N_CH   = 16,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y_in,
    output logic [SEL_W-1:0] s,
    output logic             busy,
    output logic             done,
    output logic [N_CH-1:0]  word,
    output logic             valid
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
    localparam logic [3:0]       SET_CNT  = 4'(SETTLE);
    localparam state_t           AFTER_SEL =
        (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;

    state_t            r_state;
    logic [3:0]        r_cnt;
    // The last channel goes straight into word, so only N_CH-1 bits are shadowed.
    logic [N_CH-2:0]   r_shadow;
    logic [N_CH-1:0]   w_final;

    assign w_final = {y_in, r_shadow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            s        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            word     <= '0;
            valid    <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    s    <= '0;
                    busy <= 1'b0;
                    if (start) begin
                        r_cnt   <= SET_CNT;
                        busy    <= 1'b1;
                        r_state <= AFTER_SEL;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (s == LAST_CH) begin
                        word    <= w_final;
                        valid   <= 1'b1;
                        done    <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                        parity  <= ^w_final;
`endif
                        r_state <= ST_DONE;
                    end else begin
                        r_shadow[s] <= y_in;
                        s           <= s + 1'b1;
                        r_cnt       <= SET_CNT;
                        r_state     <= AFTER_SEL;
                    end
                end
                ST_DONE: begin
                    s       <= '0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with SETTLE=1, one with SETTLE=0.
// Each instance is fed by a behavioural 16:1 mux driven from its own select.
module tb_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [15:0] in_a, in_b;
    logic        y_a, y_b;
    logic [3:0]  s_a, s_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;
    logic [15:0] word_a, word_b;
    logic        valid_a, valid_b;
`ifdef MUX_SCAN_PARITY_EN
    logic        par_a, par_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign y_a = in_a[s_a];
    assign y_b = in_b[s_b];

    mux_scan_ctrl #(.N_CH(16), .SEL_W(4), .SETTLE(1)) u_a (
        .clk   (clk),
        .rst   (rst),
        .start (start_a),
        .y_in  (y_a),
        .s     (s_a),
        .busy  (busy_a),
        .done  (done_a),
        .word  (word_a),
        .valid (valid_a)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .parity(par_a)
`endif
    );

    mux_scan_ctrl #(.N_CH(16), .SEL_W(4), .SETTLE(0)) u_b (
        .clk   (clk),
        .rst   (rst),
        .start (start_b),
        .y_in  (y_b),
        .s     (s_b),
        .busy  (busy_b),
        .done  (done_b),
        .word  (word_b),
        .valid (valid_b)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .parity(par_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse start on instance A and return at the negedge where done is high.
    task automatic scan_a(input logic [15:0] v);
        int n;
        in_a = v;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        n = 0;
        while (!done_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scan_a_done_seen", {31'd0, done_a}, 32'd1);
    endtask

    int ndone;

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_s", {28'd0, s_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_word", {16'd0, word_a}, 32'd0);
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        rst = 1'b0;

        // Basic scan, SETTLE=1: each channel holds s for 2 cycles.
        in_a = 16'h5441;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("basic_s_%0d", k), {28'd0, s_a}, 32'(k / 2));
            chk($sformatf("basic_nodone_%0d", k), {31'd0, done_a}, 32'd0);
            chk($sformatf("basic_busy_%0d", k), {31'd0, busy_a}, 32'd1);
            @(negedge clk);
        end
        chk("basic_done", {31'd0, done_a}, 32'd1);
        chk("basic_busy_done", {31'd0, busy_a}, 32'd1);
        chk("basic_word", {16'd0, word_a}, 32'h5441);
        chk("basic_valid", {31'd0, valid_a}, 32'd1);
`ifdef MUX_SCAN_PARITY_EN
        chk("basic_parity", {31'd0, par_a}, 32'd1);
`endif
        @(negedge clk);
        chk("basic_done_fall", {31'd0, done_a}, 32'd0);
        chk("basic_busy_fall", {31'd0, busy_a}, 32'd0);
        chk("basic_s_idle", {28'd0, s_a}, 32'd0);

        // Start held high through a scan: no restart, one done, rescan right after.
        in_a = 16'h00FF;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk);
        ndone = 0;
        for (int k = 0; k < 34; k++) begin
            if (k == 20) chk("hold_s_mid", {28'd0, s_a}, 32'd10);
            if (k == 32) chk("hold_word", {16'd0, word_a}, 32'h00FF);
            if (done_a) ndone++;
            @(negedge clk);
        end
        chk("hold_one_done", 32'(ndone), 32'd1);
        chk("hold_restart_busy", {31'd0, busy_a}, 32'd1);
        chk("hold_restart_s", {28'd0, s_a}, 32'd0);
        start_a = 1'b0;
        for (int n = 0; n < 200 && !done_a; n++) @(negedge clk);
        chk("hold_second_done", {31'd0, done_a}, 32'd1);
        chk("hold_second_word", {16'd0, word_a}, 32'h00FF);
        @(negedge clk);

        // Word is held through a scan in progress.
        scan_a(16'h1234);
        chk("wh_first", {16'd0, word_a}, 32'h1234);
        @(negedge clk);
        in_a = 16'hFFFF;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (20) @(negedge clk);
        chk("wh_mid", {16'd0, word_a}, 32'h1234);
        for (int n = 0; n < 200 && !done_a; n++) @(negedge clk);
        chk("wh_second", {16'd0, word_a}, 32'hFFFF);
        @(negedge clk);

`ifdef MUX_SCAN_PARITY_EN
        scan_a(16'h5441);
        chk("par_first", {31'd0, par_a}, 32'd1);
        @(negedge clk);
        scan_a(16'h5440);
        chk("par_second", {31'd0, par_a}, 32'd0);
        chk("par_word", {16'd0, word_a}, 32'h5440);
        @(negedge clk);
`endif

        // Reset in the middle of a scan clears immediately.
        in_a = 16'h5441;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int n = 0; n < 100 && s_a != 4'd7; n++) @(negedge clk);
        chk("mr_reach7", {28'd0, s_a}, 32'd7);
        rst = 1'b1;
        #1;
        chk("mr_s", {28'd0, s_a}, 32'd0);
        chk("mr_busy", {31'd0, busy_a}, 32'd0);
        chk("mr_word", {16'd0, word_a}, 32'd0);
        chk("mr_valid", {31'd0, valid_a}, 32'd0);
        chk("mr_done", {31'd0, done_a}, 32'd0);
        @(negedge clk) rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        chk("mr_no_done", 32'(ndone), 32'd0);
        scan_a(16'hBEEF);
        chk("mr_rescan_word", {16'd0, word_a}, 32'hBEEF);
        chk("mr_rescan_valid", {31'd0, valid_a}, 32'd1);
        @(negedge clk);

        // Zero settle: s advances every cycle, done after 16 cycles.
        in_b = 16'hA5C3;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("z_s_%0d", k), {28'd0, s_b}, 32'(k));
            chk($sformatf("z_nodone_%0d", k), {31'd0, done_b}, 32'd0);
            @(negedge clk);
        end
        chk("z_done", {31'd0, done_b}, 32'd1);
        chk("z_word", {16'd0, word_b}, 32'hA5C3);
        chk("z_valid", {31'd0, valid_b}, 32'd1);
        @(negedge clk);
        chk("z_busy_fall", {31'd0, busy_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
